// File: rtl/wb_uart_pkg.sv
// wb_uart_pkg: shared definitions for the Wishbone UART transmitter.
//   - block base-address byte (adr[31:24])
//   - register offsets within the block
//   - CTRL and STATUS bit positions
//   - TX frame state enum
package wb_uart_pkg;

  localparam logic [7:0] BASE_BYTE   = 8'hD2;

  localparam logic [7:0] OFF_TXDATA  = 8'h00;
  localparam logic [7:0] OFF_STATUS  = 8'h04;
  localparam logic [7:0] OFF_BAUDDIV = 8'h08;
  localparam logic [7:0] OFF_CTRL    = 8'h0C;
  localparam logic [7:0] OFF_IRQCLR  = 8'h10;

  localparam int CTRL_TX_EN    = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_FIFO_CLR = 2;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_IRQ       = 3;
  localparam int ST_LEVEL_LSB = 8;
  localparam int ST_LEVEL_W   = 5;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous DEPTH x 8 FIFO for outgoing characters.
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_push, i_push_data write side; ignored while full
//   i_pop, o_pop_data  read side; o_pop_data shows the head entry, the pop
//                      advances past it; ignored while empty
//   i_clear            empties the FIFO (wins over push/pop in that cycle)
//   o_full, o_empty, o_level  occupancy status
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [7:0]    i_push_data,
  input  logic          i_pop,
  input  logic          i_clear,
  output logic [7:0]    o_pop_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [LW-1:0] o_level
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok, pop_ok;

  assign o_full     = (level_q == LW'(DEPTH));
  assign o_empty    = (level_q == '0);
  assign o_level    = level_q;
  assign o_pop_data = mem_q[rd_ptr_q];

  // Full/empty are sampled before this cycle's pop/push, so a push into a
  // full FIFO is dropped even if a pop happens in the same cycle.
  assign push_ok = i_push & ~o_full;
  assign pop_ok  = i_pop & ~o_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      level_d = level_q + 1'b1;
      else if (!push_ok && pop_ok) level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_push_data;
  end

endmodule

// File: rtl/wb_uart_tx.sv
// wb_uart_tx: Wishbone classic responder that buffers bytes in a FIFO and
// transmits them as 8N1 serial frames on o_uart_txd.
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_wb_adr/sel/we/dat/cyc/stb  Wishbone request (block at adr[31:24]==0xD2)
//   o_wb_dat/ack/err          registered response, one cycle after accept
//   o_uart_txd                serial output, idle high
//   o_irq                     level interrupt: FIFO drained by a pop
module wb_uart_tx
  import wb_uart_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] BAUD_RESET = 16'd433
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_wb_adr,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_dat,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  output logic        o_wb_ack,
  output logic        o_wb_err,
  output logic        o_uart_txd,
  output logic        o_irq
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  // Bus response and register state
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] dat_q, dat_d;
  logic [15:0] baud_q, baud_d;
  logic        tx_en_q, tx_en_d;
  logic        irq_en_q, irq_en_d;
  logic        irq_pending_q, irq_pending_d;

  // Transmitter state
  tx_state_e   state_q, state_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd_q, txd_d;

  logic          accept, req_err;
  logic [7:0]    wb_off;
  logic [31:0]   rdata, status;
  logic          push, pop, fifo_clr, irq_clr, irq_set, bit_end;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [LW-1:0] fifo_level;
  logic          unused_bits;

  assign unused_bits = ^{i_wb_adr[23:8], i_wb_dat[31:16]};

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (push),
    .i_push_data (i_wb_dat[7:0]),
    .i_pop       (pop),
    .i_clear     (fifo_clr),
    .o_pop_data  (fifo_rdata),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty),
    .o_level     (fifo_level)
  );

  // A pending response blocks acceptance, so a strobe held across ack is
  // taken as a fresh request on the cycle after ack drops.
  assign accept = i_wb_cyc & i_wb_stb & (i_wb_adr[31:24] == BASE_BYTE)
                & ~ack_q & ~err_q;
  assign wb_off = i_wb_adr[7:0];

  always_comb begin
    status = '0;
    status[ST_FULL]  = fifo_full;
    status[ST_EMPTY] = fifo_empty;
    status[ST_BUSY]  = (state_q != TX_IDLE);
    status[ST_IRQ]   = irq_pending_q;
    status[ST_LEVEL_LSB +: ST_LEVEL_W] = ST_LEVEL_W'(fifo_level);
  end

  // Register decode; every side effect is gated by accept.
  always_comb begin
    req_err  = 1'b0;
    rdata    = '0;
    push     = 1'b0;
    fifo_clr = 1'b0;
    irq_clr  = 1'b0;
    baud_d   = baud_q;
    tx_en_d  = tx_en_q;
    irq_en_d = irq_en_q;
    case (wb_off)
      OFF_TXDATA: begin
        if (i_wb_we && i_wb_sel[0]) begin
          if (fifo_full) req_err = 1'b1;
          else           push    = accept;
        end
      end
      OFF_STATUS: rdata = status;
      OFF_BAUDDIV: begin
        rdata = {16'h0000, baud_q};
        if (accept && i_wb_we) begin
          if (i_wb_sel[0]) baud_d[7:0]  = i_wb_dat[7:0];
          if (i_wb_sel[1]) baud_d[15:8] = i_wb_dat[15:8];
        end
      end
      OFF_CTRL: begin
        rdata[CTRL_TX_EN]  = tx_en_q;
        rdata[CTRL_IRQ_EN] = irq_en_q;
        if (accept && i_wb_we && i_wb_sel[0]) begin
          tx_en_d  = i_wb_dat[CTRL_TX_EN];
          irq_en_d = i_wb_dat[CTRL_IRQ_EN];
          fifo_clr = i_wb_dat[CTRL_FIFO_CLR];
        end
      end
      OFF_IRQCLR: begin
        if (accept && i_wb_we && i_wb_sel[0]) irq_clr = i_wb_dat[0];
      end
      // Unknown and unaligned offsets both land here.
      default: req_err = 1'b1;
    endcase
    ack_d = accept & ~req_err;
    err_d = accept & req_err;
    dat_d = (accept && !i_wb_we && !req_err) ? rdata : '0;
  end

  // Drained-by-pop detection: level 1 with a pop and no simultaneous push.
  // Set has priority over IRQCLR.
  assign irq_set = pop & (fifo_level == LW'(1)) & ~push;

  always_comb begin
    irq_pending_d = irq_pending_q;
    if (irq_set)      irq_pending_d = 1'b1;
    else if (irq_clr) irq_pending_d = 1'b0;
  end

  // TX FSM: each non-idle state lasts baud_q+1 clocks. The counter is
  // reloaded from baud_q at every bit start, so a divider change lands on
  // the next bit boundary.
  assign bit_end = (baud_cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    pop        = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (tx_en_q && !fifo_empty) begin
          pop        = 1'b1;
          shift_d    = fifo_rdata;
          baud_cnt_d = baud_q;
          state_d    = TX_START;
        end
      end
      TX_START: begin
        if (bit_end) begin
          baud_cnt_d = baud_q;
          bit_cnt_d  = '0;
          state_d    = TX_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q - 1'b1;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          baud_cnt_d = baud_q;
          if (bit_cnt_q == 3'd7) begin
            state_d = TX_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 1'b1;
        end
      end
      TX_STOP: begin
        if (bit_end) state_d = TX_IDLE;
        else         baud_cnt_d = baud_cnt_q - 1'b1;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // txd is registered from the state, so the line trails the FSM by one
  // clock: push edge, pop edge, then the start bit appears.
  always_comb begin
    case (state_q)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = shift_q[0];
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
      dat_q         <= '0;
      baud_q        <= BAUD_RESET;
      tx_en_q       <= 1'b0;
      irq_en_q      <= 1'b0;
      irq_pending_q <= 1'b0;
      state_q       <= TX_IDLE;
      baud_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      txd_q         <= 1'b1;
    end else begin
      ack_q         <= ack_d;
      err_q         <= err_d;
      dat_q         <= dat_d;
      baud_q        <= baud_d;
      tx_en_q       <= tx_en_d;
      irq_en_q      <= irq_en_d;
      irq_pending_q <= irq_pending_d;
      state_q       <= state_d;
      baud_cnt_q    <= baud_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      txd_q         <= txd_d;
    end
  end

  assign o_wb_ack   = ack_q;
  assign o_wb_err   = err_q;
  assign o_wb_dat   = dat_q;
  assign o_uart_txd = txd_q;
  assign o_irq      = irq_pending_q & irq_en_q;

endmodule
